// File: rtl/dense_seq_pkg.sv
// Shared types and sizes for the dense-1 layer sequencer.
// Element bundle carried through the output skid FIFO.
package dense_seq_pkg;

  localparam int N_OUT = 128;
  localparam int AW    = 7;
  localparam int DW    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN
  } seq_state_t;

  typedef struct packed {
    logic signed [DW-1:0] data;
    logic [AW-1:0]        idx;
  } seq_elem_t;

endpackage

// File: rtl/seq_skid_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module seq_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= bump(wptr);
      end
      if (do_pop) begin
        rptr <= bump(rptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dense1_layer_sequencer.sv
// Runs one pass of the 2048->128 dense engine and drains its
// outputs into a valid/ready stream for the next classifier stage.
module dense1_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int TIMEOUT    = 2**20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  output logic          dl_start,
  input  logic          dl_done,
  output logic [AW-1:0] dl_read_addr,
  input  logic [DW-1:0] dl_read_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = AW + 1;
  localparam int EW = $bits(seq_elem_t);

  seq_state_t    state;
  seq_state_t    state_nx;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] issued;
  logic [RD_LAT-1:0] pipe_vld;
  logic [AW-1:0] pipe_idx [RD_LAT];
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   inflight;
  logic          fifo_empty;
  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          accept;
  logic          tmo;
  seq_elem_t     wr_elem;
  seq_elem_t     head;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx = S_START;
          accept   = 1'b1;
        end
      end
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (dl_done) begin
          state_nx = S_DRAIN;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nx = S_IDLE;
          tmo      = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop && head.idx == AW'(N_OUT - 1)) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dl_start  = (state == S_START);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        tcnt <= '0;
      end else if (tcnt != '1) begin
        tcnt <= tcnt + TW'(1);
      end
      if (accept) begin
        timeout_err <= 1'b0;
      end else if (tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Reads still in the engine pipe count against FIFO space.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + (CW+1)'(pipe_vld[i]);
    end
  end

  assign credit_ok = ({1'b0, fifo_cnt} + inflight) < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state == S_DRAIN) && (issued < IW'(N_OUT)) && credit_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued       <= '0;
      dl_read_addr <= '0;
    end else if (state == S_START) begin
      issued       <= '0;
      dl_read_addr <= '0;
    end else if (issue) begin
      issued <= issued + IW'(1);
      if (issued != IW'(N_OUT - 1)) begin
        dl_read_addr <= dl_read_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_idx[0] <= dl_read_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign push = pipe_vld[RD_LAT-1];
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_elem = '{data: dl_read_data, idx: pipe_idx[RD_LAT-1]};
  end

  seq_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (wr_elem),
    .pop    (pop),
    .rdata  (head),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_idx   = head.idx;
  assign out_last  = out_valid && (head.idx == AW'(N_OUT - 1));

endmodule

// File: tb/tb_dense1_layer_sequencer.sv
// Bench for dense1_layer_sequencer: two instances (RD_LAT 1 / 2)
// driven by directed frames, checked by a queue scoreboard.
module tb_dense1_layer_sequencer;

  localparam int N   = 128;
  localparam int TMO = 256;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic       dl_start [2];
  logic       dl_done [2];
  logic [6:0] dl_read_addr [2];
  logic [3:0] dl_read_data [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [3:0] out_data [2];
  logic [6:0] out_idx [2];
  logic       out_last [2];
  logic       busy [2];
  logic       timeout_err [2];

  int vectors = 0;
  int miscompares = 0;

  dense1_layer_sequencer #(
    .RD_LAT(1), .TIMEOUT(TMO), .FIFO_DEPTH(4)
  ) dut0 (
    .clk(clk), .resetn(resetn[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .dl_start(dl_start[0]), .dl_done(dl_done[0]),
    .dl_read_addr(dl_read_addr[0]), .dl_read_data(dl_read_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_idx(out_idx[0]),
    .out_last(out_last[0]), .busy(busy[0]),
    .timeout_err(timeout_err[0])
  );

  dense1_layer_sequencer #(
    .RD_LAT(2), .TIMEOUT(TMO), .FIFO_DEPTH(3)
  ) dut1 (
    .clk(clk), .resetn(resetn[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .dl_start(dl_start[1]), .dl_done(dl_done[1]),
    .dl_read_addr(dl_read_addr[1]), .dl_read_data(dl_read_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_idx(out_idx[1]),
    .out_last(out_last[1]), .busy(busy[1]),
    .timeout_err(timeout_err[1])
  );

  function automatic logic [3:0] ref_mem(input int i);
    int v;
    v = (i % 13) - 6;
    if (v < 0) v = 0;
    return 4'(v);
  endfunction

  // Engine model: done 50 cycles after start, read pipe of 1 or 2 stages.
  bit         done_en [2];
  int         dcnt [2];
  logic [3:0] rpipe [2][2];
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      rpipe[g][0] <= ref_mem(int'(dl_read_addr[g]));
      rpipe[g][1] <= rpipe[g][0];
      dl_done[g]  <= 1'b0;
      if (dl_start[g] === 1'b1) begin
        dcnt[g] <= 50;
      end else if (dcnt[g] > 0) begin
        dcnt[g] <= dcnt[g] - 1;
        if (dcnt[g] == 1 && done_en[g]) dl_done[g] <= 1'b1;
      end
    end
  end

  assign dl_read_data[0] = rpipe[0][0];
  assign dl_read_data[1] = rpipe[1][1];

  task automatic check(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got 0x%0h, required 0x%0h", name, g, act, exp);
    end
  endtask

  logic [11:0] exp_q [2][$];
  bit          stall [2];
  logic [10:0] held [2];
  bit          chk_idle [2];
  bit          seen_v [2];
  bit          seen_a [2];
  int          beats [2];
  int          frames [2];
  int          starts [2];
  int          done_cyc [2];
  int          first_v [2];
  int          first_a [2];
  int          last_a [2];

  task automatic monitor_lane(input int g);
    logic [11:0] e;
    int          fc;
    if (resetn[g] !== 1'b1) begin
      exp_q[g].delete();
      stall[g]    = 1'b0;
      chk_idle[g] = 1'b0;
      return;
    end
    if (chk_idle[g]) begin
      chk_idle[g] = 1'b0;
      check("idle_after_last", g, 32'(busy[g]), 32'd0);
    end
    if (dl_start[g]) starts[g]++;
    if (dl_done[g] && busy[g]) done_cyc[g] = cyc;
    if (req_valid[g] && req_ready[g]) begin
      seen_v[g] = 1'b0;
      seen_a[g] = 1'b0;
      if (done_en[g]) begin
        for (int i = 0; i < N; i++) begin
          exp_q[g].push_back({i == N - 1, 7'(i), ref_mem(i)});
        end
      end
    end
    if (stall[g]) begin
      check("stall_hold", g, 32'({out_valid[g], out_idx[g], out_data[g]}),
            32'({1'b1, held[g]}));
    end
    stall[g] = 1'b0;
    if (out_valid[g]) begin
      if (!seen_v[g]) begin
        seen_v[g]  = 1'b1;
        first_v[g] = cyc;
      end
      if (out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat lane%0d: got idx %0d, required no beat",
                   g, out_idx[g]);
        end else begin
          e = exp_q[g].pop_front();
          check("beat", g, 32'({out_last[g], out_idx[g], out_data[g]}), 32'(e));
        end
        beats[g]++;
        if (!seen_a[g]) begin
          seen_a[g]  = 1'b1;
          first_a[g] = cyc;
        end
        if (out_last[g]) begin
          last_a[g] = cyc;
          frames[g]++;
          chk_idle[g] = 1'b1;
        end
      end else begin
        stall[g] = 1'b1;
        held[g]  = {out_idx[g], out_data[g]};
      end
    end
    fc = (g == 0) ? int'(dut0.u_fifo.count) : int'(dut1.u_fifo.count);
    check("fifo_bound", g, 32'(fc <= ((g == 0) ? 4 : 3)), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) monitor_lane(g);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int g, input int mode, input int n);
    case (mode)
      0:       out_ready[g] = 1'b1;
      1:       out_ready[g] = ($urandom_range(0, 9) < 3);
      2:       out_ready[g] = n[0];
      default: out_ready[g] = 1'b0;
    endcase
  endtask

  task automatic start_frame(input int g);
    req_valid[g] = 1'b1;
    step();
    req_valid[g] = 1'b0;
  endtask

  task automatic finish_frame(input int g, input int mode, output int n);
    n = 0;
    while (busy[g] && n < 5000) begin
      n++;
      set_ready(g, mode, n);
      step();
    end
    if (busy[g]) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_end lane%0d: busy after %0d cycles, required idle", g, n);
    end
  endtask

  task automatic check_reset_state(input int g);
    check("reset_outputs", g,
          32'({out_valid[g], out_last[g], busy[g], timeout_err[g], dl_start[g],
               dl_read_addr[g], out_idx[g], out_data[g]}), 32'd0);
  endtask

  initial begin
    int n;
    int b0;
    int s0;
    int f0;
    for (int g = 0; g < 2; g++) begin
      resetn[g]    = 1'b0;
      req_valid[g] = 1'b0;
      out_ready[g] = 1'b0;
      done_en[g]   = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_reset_state(g);
      check("reset_req_ready", g, 32'(req_ready[g]), 32'd1);
    end
    step();
    resetn[0] = 1'b1;
    resetn[1] = 1'b1;
    step();

    // nominal, lane 0: back-to-back beats
    out_ready[0] = 1'b1;
    b0 = beats[0];
    s0 = starts[0];
    start_frame(0);
    finish_frame(0, 0, n);
    check("nom_beats", 0, 32'(beats[0] - b0), 32'd128);
    check("nom_starts", 0, 32'(starts[0] - s0), 32'd1);
    check("nom_span", 0, 32'(last_a[0] - first_a[0]), 32'd127);
    check("nom_latency", 0, 32'(first_v[0] - done_cyc[0]), 32'd3);

    // nominal, lane 1
    out_ready[1] = 1'b1;
    b0 = beats[1];
    start_frame(1);
    finish_frame(1, 0, n);
    check("nom_beats", 1, 32'(beats[1] - b0), 32'd128);
    check("nom_latency", 1, 32'(first_v[1] - done_cyc[1]), 32'd4);

    // backpressure, lane 0
    b0 = beats[0];
    f0 = frames[0];
    set_ready(0, 1, 0);
    start_frame(0);
    finish_frame(0, 1, n);
    check("bp_beats", 0, 32'(beats[0] - b0), 32'd128);
    check("bp_frames", 0, 32'(frames[0] - f0), 32'd1);

    // timeout, lane 0
    done_en[0] = 1'b0;
    b0 = beats[0];
    start_frame(0);
    finish_frame(0, 0, n);
    check("tmo_cycles", 0, 32'(n), 32'd257);
    check("tmo_err", 0, 32'(timeout_err[0]), 32'd1);
    check("tmo_no_beats", 0, 32'(beats[0] - b0), 32'd0);
    done_en[0] = 1'b1;
    start_frame(0);
    check("tmo_err_clear", 0, 32'(timeout_err[0]), 32'd0);
    finish_frame(0, 0, n);
    check("tmo_recover_beats", 0, 32'(beats[0] - b0), 32'd128);

    // reset mid-drain, lane 0
    b0 = beats[0];
    out_ready[0] = 1'b1;
    start_frame(0);
    n = 0;
    while (beats[0] - b0 < 40 && n < 1000) begin
      n++;
      step();
    end
    check("rst_reach_40", 0, 32'(beats[0] - b0), 32'd40);
    out_ready[0] = 1'b0;
    step();
    step();
    resetn[0] = 1'b0;
    #1;
    check_reset_state(0);
    step();
    step();
    resetn[0] = 1'b1;
    out_ready[0] = 1'b1;
    step();
    b0 = beats[0];
    start_frame(0);
    finish_frame(0, 0, n);
    check("rst_restart_beats", 0, 32'(beats[0] - b0), 32'd128);
    check("rst_restart_latency", 0, 32'(first_v[0] - done_cyc[0]), 32'd3);

    // request held high across two frames, lane 0
    b0 = beats[0];
    s0 = starts[0];
    f0 = frames[0];
    req_valid[0] = 1'b1;
    n = 0;
    while (frames[0] - f0 < 2 && n < 2000) begin
      n++;
      step();
      if (busy[0]) check("busy_req_ready", 0, 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    finish_frame(0, 0, n);
    check("hold_starts", 0, 32'(starts[0] - s0), 32'd2);
    check("hold_beats", 0, 32'(beats[0] - b0), 32'd256);

    // toggling ready, lane 1
    b0 = beats[1];
    set_ready(1, 2, 0);
    start_frame(1);
    finish_frame(1, 2, n);
    check("tog_beats", 1, 32'(beats[1] - b0), 32'd128);
    check("tog_latency", 1, 32'(first_v[1] - done_cyc[1]), 32'd4);

    step();
    step();
    check("sb_drained", 0, 32'(exp_q[0].size()), 32'd0);
    check("sb_drained", 1, 32'(exp_q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
